// File: rtl/nvram_upload_responder_if.sv
// HPS upload channel plus save-RAM read port shared by the upload responder.
interface nvram_upload_responder_if #(
  parameter int ADDR_W = 8
);
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              ioctl_upload_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_rdata,
    input  ioctl_din, ioctl_wait, ioctl_upload_req, mem_addr, mem_rd
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_rdata,
    output ioctl_din, ioctl_wait, ioctl_upload_req, mem_addr, mem_rd
  );
endinterface

// File: rtl/nvram_upload_responder.sv
// Serves HPS save-file uploads from the core's battery RAM and requests an
// autosave once the core has written the RAM and then gone quiet.
module nvram_upload_responder #(
  parameter int         ADDR_W         = 8,
  parameter int         LATENCY        = 1,
  parameter logic [7:0] IDX            = 8'd4,
  parameter int         AUTOSAVE_TICKS = 25_000_000
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  nvram_upload_responder_if.slave bus,
  output logic                   pause_req,
  input  logic                   pause_ack,
  input  logic                   core_wr,
  output logic                   busy,
  output logic                   dirty
);

  localparam int                 TIMER_W  = (AUTOSAVE_TICKS > 1) ? $clog2(AUTOSAVE_TICKS) : 1;
  localparam logic [TIMER_W-1:0] TERMINAL = TIMER_W'(AUTOSAVE_TICKS - 1);
  localparam logic [24:0]        SPAN     = 25'(1) << ADDR_W;

  typedef enum logic [1:0] {IDLE, PAUSE, READY, FETCH} state_t;

  state_t              state_q, state_d;
  logic                pause_q, pause_d;
  logic                wait_q, wait_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          din_q, din_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                rewrite_q, rewrite_d;
  logic                dirty_q, dirty_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                armed_q, armed_d;
  logic                active, in_range, exit_up, counting, upload_req;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      pause_q    <= 1'b0;
      wait_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      din_q      <= 8'h00;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      rewrite_q  <= 1'b0;
      dirty_q    <= 1'b0;
      timer_q    <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pause_q    <= pause_d;
      wait_q     <= wait_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      din_q      <= din_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      rewrite_q  <= rewrite_d;
      dirty_q    <= dirty_d;
      timer_q    <= timer_d;
      armed_q    <= armed_d;
    end
  end

  always_comb begin
    active     = bus.ioctl_upload && (bus.ioctl_index == IDX);
    in_range   = bus.ioctl_addr < SPAN;
    exit_up    = 1'b0;
    state_d    = state_q;
    pause_d    = pause_q;
    wait_d     = wait_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    din_d      = din_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    rewrite_d  = rewrite_q | (core_wr && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (active) begin
          state_d = PAUSE;
          pause_d = 1'b1;
          wait_d  = 1'b1;
        end
      end
      PAUSE: begin
        if (!active) begin
          exit_up = 1'b1;
        end else if (pause_ack) begin
          state_d = READY;
          wait_d  = 1'b0;
        end
      end
      READY: begin
        if (!active) begin
          exit_up = 1'b1;
        end else if (bus.ioctl_rd) begin
          if (in_range) begin
            mem_addr_d = bus.ioctl_addr[ADDR_W-1:0];
            mem_rd_d   = 1'b1;
            wait_d     = 1'b1;
            cnt_d      = '0;
            state_d    = FETCH;
          end else begin
            din_d = 8'hFF;
          end
        end
      end
      FETCH: begin
        // cnt counts cycles since mem_rd; data is valid when it equals LATENCY
        if (!active) begin
          exit_up = 1'b1;
        end else if (cnt_q == 2'(LATENCY)) begin
          din_d   = bus.mem_rdata;
          wait_d  = 1'b0;
          state_d = READY;
          if (mem_addr_q == '1) last_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (exit_up) begin
      state_d   = IDLE;
      pause_d   = 1'b0;
      wait_d    = 1'b0;
      mem_rd_d  = 1'b0;
      last_d    = 1'b0;
      rewrite_d = 1'b0;
    end
  end

  // A save only counts if the final byte went out and the core stayed quiet throughout.
  always_comb begin
    dirty_d = dirty_q;
    if (exit_up && last_q && !rewrite_q && !core_wr) dirty_d = 1'b0;
    if (core_wr) dirty_d = 1'b1;

    counting   = dirty_q && (state_q == IDLE) && armed_q;
    upload_req = counting && (timer_q == TERMINAL) && !core_wr && !reset;

    timer_d = timer_q;
    armed_d = armed_q;
    if (core_wr) begin
      timer_d = '0;
      armed_d = 1'b1;
    end else if (upload_req) begin
      armed_d = 1'b0;
    end else if (counting && (timer_q != TERMINAL)) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  assign bus.ioctl_din        = din_q;
  assign bus.ioctl_wait       = wait_q;
  assign bus.ioctl_upload_req = upload_req;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_rd           = mem_rd_q;
  assign pause_req            = pause_q;
  assign busy                 = (state_q != IDLE);
  assign dirty                = dirty_q;

endmodule

// File: tb/tb_nvram_upload_responder.sv
// Directed/randomised bench for nvram_upload_responder with a 2-cycle RAM model.
module tb_nvram_upload_responder;

  localparam int LAT   = 2;
  localparam int TICKS = 100;

  logic clk, reset, pause_req, pause_ack, core_wr, busy, dirty;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   pulse_q[$];
  logic [7:0] ram [256];
  logic [7:0] a1, a2;
  logic       v1, v2;
  logic       model_dirty, served_last, wr_busy;

  nvram_upload_responder_if #(.ADDR_W(8)) bus();

  nvram_upload_responder #(
    .ADDR_W(8), .LATENCY(LAT), .IDX(8'd4), .AUTOSAVE_TICKS(TICKS)
  ) dut (
    .clk_sys(clk), .reset(reset), .bus(bus), .pause_req(pause_req),
    .pause_ack(pause_ack), .core_wr(core_wr), .busy(busy), .dirty(dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM returns inverted data until the latency has elapsed, so early capture is visible.
  always @(posedge clk) begin
    v1 <= bus.mem_rd;  a1 <= bus.mem_addr;
    v2 <= v1;          a2 <= a1;
  end
  assign bus.mem_rdata = v2 ? ram[a2] : ~ram[a2];

  always @(negedge clk) if (bus.ioctl_upload_req) pulse_q.push_back(cyc);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_wr();
    core_wr = 1'b1;
    model_dirty = 1'b1;
    if (busy) wr_busy = 1'b1;
    tick();
    core_wr = 1'b0;
  endtask

  task automatic start_upload(input int ack_delay);
    bus.ioctl_upload = 1'b1;
    bus.ioctl_index  = 8'd4;
    served_last = 1'b0;
    wr_busy     = 1'b0;
    for (int k = 1; k <= ack_delay; k++) begin
      tick();
      bus.ioctl_rd = (k == 1);
      bus.ioctl_addr = 25'd7;
      check("pause_req_start", pause_req, 1);
      check("wait_in_pause", bus.ioctl_wait, 1);
      if (k > 1) check("rd_ignored_in_pause", bus.mem_rd, 0);
      if (k == ack_delay) pause_ack = 1'b1;
    end
    tick();
    check("wait_after_ack", bus.ioctl_wait, 0);
    check("busy_ready", busy, 1);
  endtask

  task automatic do_read(input logic [24:0] a);
    logic [7:0] exp;
    exp = (a < 25'd256) ? ram[a[7:0]] : 8'hFF;
    bus.ioctl_rd = 1'b1;
    bus.ioctl_addr = a;
    tick();
    bus.ioctl_rd = 1'b0;
    if (a < 25'd256) begin
      check("mem_rd_strobe", bus.mem_rd, 1);
      check("mem_addr", bus.mem_addr, a[7:0]);
      check("wait_fetch", bus.ioctl_wait, 1);
      for (int i = 0; i < LAT; i++) begin
        tick();
        check("wait_hold", bus.ioctl_wait, 1);
        check("mem_rd_single", bus.mem_rd, 0);
      end
      tick();
      check("wait_done", bus.ioctl_wait, 0);
      check("din_data", bus.ioctl_din, exp);
      if (a == 25'd255) served_last = 1'b1;
    end else begin
      check("din_oor", bus.ioctl_din, exp);
      check("wait_oor", bus.ioctl_wait, 0);
      check("mem_rd_oor", bus.mem_rd, 0);
      tick();
      check("mem_rd_oor_late", bus.mem_rd, 0);
    end
  endtask

  task automatic end_upload();
    bus.ioctl_upload = 1'b0;
    if (served_last && !wr_busy) model_dirty = 1'b0;
    tick();
    pause_ack = 1'b0;
    check("busy_exit", busy, 0);
    check("pause_req_exit", pause_req, 0);
    check("wait_exit", bus.ioctl_wait, 0);
    check("dirty_exit", dirty, model_dirty);
  endtask

  initial begin
    int c, x;
    logic [7:0] keep;
    reset = 1'b1; pause_ack = 1'b0; core_wr = 1'b0;
    bus.ioctl_upload = 1'b0; bus.ioctl_index = 8'd0;
    bus.ioctl_rd = 1'b0; bus.ioctl_addr = '0;
    model_dirty = 1'b0; served_last = 1'b0; wr_busy = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    ram[8'h10] = 8'hA5;
    ram[8'h30] = ~ram[8'h05];

    tick(); tick();
    check("rst_din", bus.ioctl_din, 8'h00);
    check("rst_wait", bus.ioctl_wait, 0);
    check("rst_pause", pause_req, 0);
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_dirty", dirty, 0);
    check("rst_req", bus.ioctl_upload_req, 0);
    reset = 1'b0;
    tick();

    // single write: one pulse 100 cycles later
    pulse_q.delete();
    c = cyc;
    pulse_wr();
    check("dirty_set", dirty, 1);
    repeat (150) tick();
    check("as1_count", pulse_q.size(), 1);
    check("as1_cycle", (pulse_q.size() > 0) ? pulse_q[0] : -1, c + TICKS);

    // second write 50 cycles in restarts the quiet period
    pulse_q.delete();
    c = cyc;
    pulse_wr();
    repeat (49) tick();
    pulse_wr();
    repeat (150) tick();
    check("as2_count", pulse_q.size(), 1);
    check("as2_cycle", (pulse_q.size() > 0) ? pulse_q[0] : -1, c + 150);

    // write landing on the terminal count suppresses that pulse
    pulse_q.delete();
    c = cyc;
    pulse_wr();
    repeat (99) tick();
    pulse_wr();
    repeat (150) tick();
    check("as3_count", pulse_q.size(), 1);
    check("as3_cycle", (pulse_q.size() > 0) ? pulse_q[0] : -1, c + 2 * TICKS);

    // wrong index is not ours
    bus.ioctl_upload = 1'b1; bus.ioctl_index = 8'd3;
    repeat (3) tick();
    check("other_idx_busy", busy, 0);
    check("other_idx_pause", pause_req, 0);
    bus.ioctl_upload = 1'b0;
    tick();

    // clean full upload clears dirty
    pulse_q.delete();
    start_upload(5);
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h10;
    tick();
    bus.ioctl_rd = 1'b0;
    check("rd_mem_rd", bus.mem_rd, 1);
    check("rd_mem_addr", bus.mem_addr, 8'h10);
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h20;
    tick();
    bus.ioctl_rd = 1'b0;
    check("rd_fetch_ignored", bus.mem_rd, 0);
    tick();
    check("rd_wait_t3", bus.ioctl_wait, 1);
    tick();
    check("rd_din_a5", bus.ioctl_din, 8'hA5);
    check("rd_wait_t4", bus.ioctl_wait, 0);
    tick();
    check("rd_no_refetch", bus.mem_rd, 0);
    check("rd_din_keep", bus.ioctl_din, 8'hA5);
    do_read(25'h100);
    do_read(25'h1000010);
    for (int a = 0; a < 256; a++) do_read(25'(a));
    check("dirty_before_exit", dirty, 1);
    end_upload();
    check("up1_no_pulse", pulse_q.size(), 0);

    // core write during upload keeps dirty and rearms autosave
    start_upload(2);
    pulse_q.delete();
    for (int a = 0; a < 256; a++) begin
      if (a == 128) pulse_wr();
      do_read(25'(a));
    end
    end_upload();
    x = cyc;
    check("up2_no_pulse_busy", pulse_q.size(), 0);
    repeat (120) tick();
    check("up2_pulse_count", pulse_q.size(), 1);
    check("up2_pulse_cycle", (pulse_q.size() > 0) ? pulse_q[0] : -1, x + TICKS - 1);

    // abort mid-fetch
    start_upload(2);
    do_read(25'h05);
    keep = ram[8'h05];
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h30;
    tick();
    bus.ioctl_rd = 1'b0;
    check("abort_mem_rd", bus.mem_rd, 1);
    tick();
    bus.ioctl_upload = 1'b0;
    tick();
    pause_ack = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_wait", bus.ioctl_wait, 0);
    check("abort_pause", pause_req, 0);
    check("abort_din", bus.ioctl_din, keep);
    repeat (3) tick();
    check("abort_din_late", bus.ioctl_din, keep);
    check("abort_dirty", dirty, model_dirty);

    // reset during fetch
    start_upload(2);
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h40;
    tick();
    bus.ioctl_rd = 1'b0;
    reset = 1'b1;
    tick();
    check("mid_rst_din", bus.ioctl_din, 8'h00);
    check("mid_rst_wait", bus.ioctl_wait, 0);
    check("mid_rst_pause", pause_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mem_rd", bus.mem_rd, 0);
    check("mid_rst_dirty", dirty, 0);
    reset = 1'b0;
    bus.ioctl_upload = 1'b0;
    pause_ack = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
